riscv_data_memory: RTL and testbench
====================================

RISCV_DATA_MEMORY -- requirements
Module: riscv_data_memory

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit data words; power of two, 2 to 4096.
REQ-002 Parameter BASE_ADDR, default 32'h10010000: byte address of word 0; DEPTH*4-aligned.
REQ-003 Parameter TIMER_ADDR, default 32'hFFFF0000: byte address of the memory-mapped cycle timer.
REQ-004 Parameter LED_ADDR, default 32'hFFFF0004: byte address of the memory-mapped LED register.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 MemRead  input  1  read request, one cycle per access.
REQ-008 MemWrite  input  1  write request, one cycle per access.
REQ-009 dAddress  input  32  byte address of the access.
REQ-010 dWriteData  input  32  store data, sampled with MemWrite.
REQ-011 dReadData  output  32  registered load data.
REQ-012 LED  output  16  LED register, low 16 bits.
REQ-013 err  output  1  sticky access-error flag.

Function
REQ-014 Region decode SHALL be: RAM if BASE_ADDR <= dAddress < BASE_ADDR+DEPTH*4; TIMER if dAddress==TIMER_ADDR; LED if dAddress==LED_ADDR; otherwise unmapped.
REQ-015 RAM word index SHALL be (dAddress-BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
REQ-016 An access is valid only if exactly one of MemRead/MemWrite is high, dAddress[1:0]==0 and the region is mapped.
REQ-017 Valid write SHALL update the target at the same edge: RAM word, timer load, or LED <= dWriteData[15:0].
REQ-018 Valid read SHALL register the target value into dReadData at that edge; data is visible the cycle after MemRead, one-cycle latency.
REQ-019 LED read SHALL return {16'h0, LED}.
REQ-020 dReadData SHALL hold its value until the next valid read completes; writes and idle cycles do not change it.
REQ-021 Invalid access SHALL modify no storage, SHALL load dReadData with 32'h0 if MemRead was high, and SHALL set err.
REQ-022 MemRead and MemWrite high together SHALL be invalid: neither operation performed.
REQ-023 Write then read of the same RAM word on consecutive cycles SHALL return the newly written data.
REQ-024 Timer: 32-bit free-running counter, +1 every cycle, wraps 32'hFFFFFFFF to 0.
REQ-025 Timer write SHALL load dWriteData and suppress that cycle's increment; the following cycle resumes from the loaded value +1.
REQ-026 Timer read SHALL return the counter value before that edge's increment.
REQ-027 Access FSM states: IDLE (no access last cycle), RDATA (valid read completed last cycle), WDONE (valid write completed last cycle), FAULT (invalid access last cycle).
REQ-028 FSM next state SHALL be chosen from the current inputs only, every cycle, from any state; the state is observable for verification, and dReadData/err follow REQ-018 to REQ-021.
REQ-029 err SHALL remain 1 once set until rst.

Reset
REQ-030 On rst high at a clock edge: dReadData=0, LED=0, err=0, timer=0, FSM=IDLE.
REQ-031 Requests coinciding with rst SHALL be ignored; RAM contents are not cleared and are preserved across reset.
REQ-032 First cycle after rst deasserts: timer=0, then increments.

Verification
REQ-033 Write 32'hDEADBEEF to 0x10010008, then MemRead 0x10010008 next cycle -> dReadData=32'hDEADBEEF one cycle after MemRead; err=0.
REQ-034 MemRead 0x10010002 (misaligned) -> dReadData=0, err=1 and stays 1 through 10 idle cycles; RAM unchanged on readback.
REQ-035 MemWrite 32'h0001ABCD to LED_ADDR -> LED=16'hABCD next cycle; read LED_ADDR -> 32'h0000ABCD.
REQ-036 Write 32'hFFFFFFFE to TIMER_ADDR, idle 3 cycles, read -> 32'h00000001 (wrap verified).
REQ-037 MemRead and MemWrite both high at 0x10010000 with dWriteData=32'h12345678 -> word unchanged, dReadData=0, err=1.
REQ-038 Write 32'hCAFEF00D to 0x10010010, pulse rst, read 0x10010010 -> 32'hCAFEF00D; LED=0, err=0 after rst.

Source files
------------

// File: rtl/riscv_data_memory.sv
// Data memory for a small RISC-V core: word RAM plus a memory-mapped cycle timer and LED register.
// Loads are registered (one-cycle latency); bad accesses set a sticky err flag.
module riscv_data_memory #(
  parameter int          DEPTH      = 512,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000,
  parameter logic [31:0] TIMER_ADDR = 32'hFFFF0000,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic [15:0] LED,
  output logic        err,
  output logic [1:0]  o_state     // 0 IDLE, 1 RDATA, 2 WDONE, 3 FAULT
);

  // state  | meaning
  // IDLE   | no access last cycle
  // RDATA  | valid read completed last cycle
  // WDONE  | valid write completed last cycle
  // FAULT  | invalid access last cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RDATA = 2'd1,
    S_WDONE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_timer;
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic        r_err;

  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_hit_ram;
  logic          w_hit_timer;
  logic          w_hit_led;
  logic          w_any_req;
  logic          w_valid;
  logic          w_rd;
  logic          w_wr;

  always_comb begin
    w_offset    = dAddress - BASE_ADDR;
    w_idx       = w_offset[AW+1:2];
    w_hit_ram   = (dAddress >= BASE_ADDR) && (w_offset < RAM_BYTES);
    w_hit_timer = (dAddress == TIMER_ADDR);
    w_hit_led   = (dAddress == LED_ADDR);
    w_any_req   = MemRead | MemWrite;
    w_valid     = (MemRead ^ MemWrite) && (dAddress[1:0] == 2'b00) &&
                  (w_hit_ram || w_hit_timer || w_hit_led);
    w_rd        = w_valid & MemRead;
    w_wr        = w_valid & MemWrite;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_rd)
      w_state_nxt = S_RDATA;
    else if (w_wr)
      w_state_nxt = S_WDONE;
    else if (w_any_req)
      w_state_nxt = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // RAM is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr && w_hit_ram)
      r_mem[w_idx] <= dWriteData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_led   <= 16'h0;
      r_err   <= 1'b0;
      r_timer <= 32'h0;
    end else begin
      // a timer store replaces that cycle's increment
      if (w_wr && !w_hit_ram && w_hit_timer)
        r_timer <= dWriteData;
      else
        r_timer <= r_timer + 32'd1;

      if (w_wr && !w_hit_ram && !w_hit_timer && w_hit_led)
        r_led <= dWriteData[15:0];

      if (w_any_req && !w_valid)
        r_err <= 1'b1;

      if (w_rd) begin
        if (w_hit_ram)
          r_rdata <= r_mem[w_idx];
        else if (w_hit_timer)
          r_rdata <= r_timer;
        else
          r_rdata <= {16'h0, r_led};
      end else if (MemRead && !w_valid) begin
        r_rdata <= 32'h0;
      end
    end
  end

  assign dReadData = r_rdata;
  assign LED       = r_led;
  assign err       = r_err;
  assign o_state   = r_state;

endmodule

// File: tb/tb_riscv_data_memory.sv
// Bench for riscv_data_memory: directed scenarios, then random traffic against a
// word-level reference model of the memory map.
module tb_riscv_data_memory;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam logic [31:0] TADDR = 32'hFFFF0000;
  localparam logic [31:0] LADDR = 32'hFFFF0004;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RDATA = 2'd1;
  localparam logic [1:0] ST_WDONE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dAddress = 32'h0;
  logic [31:0] dWriteData = 32'h0;
  logic [31:0] dReadData;
  logic [15:0] LED;
  logic        err;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  riscv_data_memory #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMER_ADDR(TADDR), .LED_ADDR(LADDR)
  ) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData),
    .LED(LED), .err(err), .o_state(o_state)
  );

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_timer = 32'h0;
  logic [15:0] m_led = 16'h0;
  logic        m_err = 1'b0;
  logic [1:0]  m_state = ST_IDLE;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, from the memory-map rules.
  task automatic model_edge(input logic r, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd);
    longint unsigned ua;
    bit in_ram, is_t, is_l, ok;
    logic [31:0] t_before;
    int idx;
    if (r) begin
      m_rdata = 0; m_led = 0; m_err = 0; m_timer = 0; m_state = ST_IDLE;
      return;
    end
    ua     = longint'(a);
    in_ram = (ua >= longint'(BASE)) && (ua < longint'(BASE) + DEPTH * 4);
    is_t   = (a == TADDR);
    is_l   = (a == LADDR);
    ok     = (rd != wr) && (a % 4 == 0) && (in_ram || is_t || is_l);
    idx    = int'((ua - longint'(BASE)) / 4);
    t_before = m_timer;
    m_timer  = m_timer + 1;
    m_state  = ST_IDLE;
    if (ok && wr) begin
      m_state = ST_WDONE;
      if (in_ram) m_mem[idx] = wd;
      else if (is_t) m_timer = wd;
      else m_led = wd[15:0];
    end else if (ok && rd) begin
      m_state = ST_RDATA;
      if (in_ram) m_rdata = m_mem[idx];
      else if (is_t) m_rdata = t_before;
      else m_rdata = {16'h0, m_led};
    end else if (rd || wr) begin
      m_state = ST_FAULT;
      m_err   = 1'b1;
      if (rd) m_rdata = 32'h0;
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd);
    rst = r; MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = wd;
    @(posedge clk);
    model_edge(r, rd, wr, a, wd);
    #1;
    check("rdata", dReadData, m_rdata);
    check("led", {16'h0, LED}, {16'h0, m_led});
    check("err", {31'h0, err}, {31'h0, m_err});
    check("state", {30'h0, o_state}, {30'h0, m_state});
    rst = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    int          k;

    // reset, with a write request that must be ignored
    step(1, 0, 1, LADDR, 32'h0000FFFF);
    check("reset_led", {16'h0, LED}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_rdata", dReadData, 32'h0);
    // first cycle after reset sees timer 0
    step(0, 1, 0, TADDR, 32'h0);
    check("timer_after_rst", dReadData, 32'h0);

    // give every RAM word a known value
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, BASE + 32'(i * 4), $urandom);

    // store then immediate load
    step(0, 0, 1, 32'h10010008, 32'hDEADBEEF);
    step(0, 1, 0, 32'h10010008, 32'h0);
    check("wr_rd_same_word", dReadData, 32'hDEADBEEF);
    check("wr_rd_err", {31'h0, err}, 32'h0);
    idle(2);
    check("rdata_held", dReadData, 32'hDEADBEEF);

    // LED register
    step(0, 0, 1, LADDR, 32'h0001ABCD);
    check("led_write", {16'h0, LED}, 32'h0000ABCD);
    step(0, 1, 0, LADDR, 32'h0);
    check("led_read", dReadData, 32'h0000ABCD);

    // timer wrap
    step(0, 0, 1, TADDR, 32'hFFFFFFFE);
    idle(3);
    step(0, 1, 0, TADDR, 32'h0);
    check("timer_wrap", dReadData, 32'h00000001);

    // misaligned read: zero data, sticky err
    step(0, 1, 0, 32'h10010002, 32'h0);
    check("misaligned_rdata", dReadData, 32'h0);
    check("misaligned_err", {31'h0, err}, 32'h1);
    idle(10);
    check("err_sticky", {31'h0, err}, 32'h1);
    step(0, 1, 0, 32'h10010000, 32'h0);

    // read and write together
    step(0, 1, 0, 32'h10010008, 32'h0);
    step(0, 1, 1, 32'h10010000, 32'h12345678);
    check("both_rdata", dReadData, 32'h0);
    step(0, 1, 0, 32'h10010000, 32'h0);
    check("both_unchanged", dReadData, m_mem[0]);

    // RAM survives reset
    step(0, 0, 1, 32'h10010010, 32'hCAFEF00D);
    step(1, 0, 0, 32'h0, 32'h0);
    check("rst_err_clear", {31'h0, err}, 32'h0);
    check("rst_led_clear", {16'h0, LED}, 32'h0);
    step(0, 1, 0, 32'h10010010, 32'h0);
    check("ram_kept", dReadData, 32'hCAFEF00D);

    // unmapped boundaries
    step(0, 1, 0, BASE + 32'(DEPTH * 4), 32'h0);
    check("past_end_err", {31'h0, err}, 32'h1);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, BASE - 32'd4, 32'h55);
    check("below_base_err", {31'h0, err}, 32'h1);
    step(1, 0, 0, 32'h0, 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 3: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        4:          a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        5:          a = TADDR;
        6:          a = LADDR;
        7:          a = ($urandom_range(0, 1) == 1) ? BASE + 32'(DEPTH * 4) : TADDR + 32'd8;
        default:    a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      wd = $urandom;
      k  = int'($urandom_range(0, 19));
      rd = (k < 9) || (k == 18);
      wr = ((k >= 9) && (k < 17)) || (k == 18);
      step($urandom_range(0, 29) == 0, rd, wr, a, wd);
      if ($urandom_range(0, 24) == 0) step(1, 0, 0, 32'h0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
